// File: rtl/msg_schedule_pkg.sv
// Shared SHA256 schedule constants, FSM encodings and the small sigma helpers.
`timescale 1ns/1ps
package msg_schedule_pkg;

    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 512;
    localparam int ROUNDS  = 64;
    localparam int WIN     = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef logic [WORD_W-1:0] word_t;

    function automatic word_t sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/msg_schedule_if.sv
// Block-load / schedule-word stream bundle between the controller and msg_schedule.
`timescale 1ns/1ps
interface msg_schedule_if;
    import msg_schedule_pkg::*;

    logic               start;
    logic [BLOCK_W-1:0] block;
    logic               busy;
    logic               msg_valid;
    word_t              msg;
    logic [5:0]         round;
    logic               first;
    logic               last;
    logic               done;

    modport master (
        output start, block,
        input  busy, msg_valid, msg, round, first, last, done
    );

    modport slave (
        input  start, block,
        output busy, msg_valid, msg, round, first, last, done
    );

endinterface

// File: rtl/msg_schedule_sched_word.sv
// Combinational next schedule word from the four window taps, mod 2^32.
`timescale 1ns/1ps
module sched_word
    import msg_schedule_pkg::*;
(
    input  word_t i_w0,
    input  word_t i_w1,
    input  word_t i_w9,
    input  word_t i_w14,
    output word_t o_wnext
);

    assign o_wnext = sigma1(i_w14) + i_w9 + sigma0(i_w1) + i_w0;

endmodule

// File: rtl/msg_schedule.sv
// SHA256 message expansion: loads one block and streams W0..W63, one word per clock.
`timescale 1ns/1ps
module msg_schedule
    import msg_schedule_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    msg_schedule_if.slave bus
);

    // state | meaning
    // IDLE  | window frozen, waiting for start
    // RUN   | one schedule word per cycle on msg, round counts 0..63
    logic [0:0] r_state;
    word_t      r_win [WIN];
    logic [5:0] r_round;
    logic       r_done;
    word_t      w_next;
    logic       w_run;

    sched_word u_sched_word (
        .i_w0    (r_win[0]),
        .i_w1    (r_win[1]),
        .i_w9    (r_win[9]),
        .i_w14   (r_win[14]),
        .o_wnext (w_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_round <= '0;
            r_done  <= 1'b0;
            for (int i = 0; i < WIN; i++) r_win[i] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < WIN; i++)
                            r_win[i] <= bus.block[BLOCK_W-1-i*WORD_W -: WORD_W];
                        r_round <= '0;
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    // Words past W63 still shift in; they are never presented.
                    for (int i = 0; i < WIN-1; i++) r_win[i] <= r_win[i+1];
                    r_win[WIN-1] <= w_next;
                    if (r_round == 6'(ROUNDS-1)) begin
                        r_round <= '0;
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_round <= r_round + 6'd1;
                    end
                end
            endcase
        end
    end

    assign w_run         = (r_state == ST_RUN);
    assign bus.busy      = w_run;
    assign bus.msg_valid = w_run;
    assign bus.msg       = r_win[0];
    assign bus.round     = r_round;
    assign bus.first     = w_run && (r_round == 6'd0);
    assign bus.last      = w_run && (r_round == 6'(ROUNDS-1));
    assign bus.done      = r_done;

endmodule
